noc_node_injector: RTL and testbench

NOC_NODE_INJECTOR -- requirements
Module: noc_node_injector

---
 rtl/noc_node_injector_if.sv | 22 ++
 rtl/noc_node_injector.sv | 112 +++++++++++
 tb/tb_noc_node_injector.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_node_injector_if.sv
// Request and packet signals between a traffic source and the node injector.
// The source also drives the delivery strobe coming back from the attached router.
interface noc_node_injector_if #(
   parameter int K  = 6,
   parameter int N2 = 13
);
   logic          req_valid;
   logic [K-1:0]  req_dest;
   logic          req_ready;
   logic [N2-1:0] out_free;
   logic          in_data;

   modport master (
      output req_valid, req_dest, in_data,
      input  req_ready, out_free
   );

   modport slave (
      input  req_valid, req_dest, in_data,
      output req_ready, out_free
   );
endinterface

// File: rtl/noc_node_injector.sv
// Compute-node injector: queues destination requests, emits one single-cycle packet
// to the local router port with a fixed idle spacing, and keeps tx/rx/error counters.
module noc_node_injector #(
   parameter int K     = 6,
   parameter int N2    = 13,
   parameter int NODES = 36,
   parameter int DEPTH = 4,
   parameter int GAP   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [K-1:0] router_name,
   noc_node_injector_if.slave bus,
   output logic [7:0]   tx_count,
   output logic [7:0]   rx_count,
   output logic [7:0]   err_count,
   output logic         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [K:0] NODES_LIM = (K+1)'(NODES);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   state_t         state_reg, state_next;
   logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [GW-1:0]  gap_cnt_reg;
   logic [N2-1:0]  out_free_reg;
   logic [7:0]     tx_reg, rx_reg, err_reg;
   logic [K-1:0]   mem [DEPTH];
   logic [K-1:0]   head;
   logic [N2-1:0]  pkt;
   logic           empty, full, handshake, legal, push, bad, pop;

   // The node's own number only matters to the attached router.
   logic unused_router;
   assign unused_router = ^router_name;

   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign handshake = bus.req_valid && !full;
   assign legal     = ({1'b0, bus.req_dest} < NODES_LIM);
   assign push      = handshake && legal;
   assign bad       = handshake && !legal;
   assign head      = mem[rd_ptr_reg[AW-1:0]];

   always_comb begin
      pkt         = '0;
      pkt[N2-1]   = 1'b1;
      pkt[K-1:0]  = head;
   end

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: if (!empty) begin
            state_next = ST_SEND;
            pop        = 1'b1;
         end
         ST_SEND: state_next = ST_GAP;
         // Leaving one cycle early lets the IDLE cycle count as the last quiet cycle.
         ST_GAP:  if (gap_cnt_reg <= GW'(1)) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         gap_cnt_reg  <= '0;
         out_free_reg <= '0;
      end else begin
         state_reg    <= state_next;
         out_free_reg <= pop ? pkt : '0;
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (state_reg == ST_SEND)
            gap_cnt_reg <= GW'(GAP - 1);
         else if (state_reg == ST_GAP && gap_cnt_reg != '0)
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= bus.req_dest;
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_reg  <= '0;
         rx_reg  <= '0;
         err_reg <= '0;
      end else begin
         if (pop && tx_reg != 8'hFF)         tx_reg  <= tx_reg + 8'd1;
         if (bus.in_data && rx_reg != 8'hFF) rx_reg  <= rx_reg + 8'd1;
         if (bad && err_reg != 8'hFF)        err_reg <= err_reg + 8'd1;
      end
   end

   assign bus.req_ready = !full;
   assign bus.out_free  = out_free_reg;
   assign tx_count      = tx_reg;
   assign rx_count      = rx_reg;
   assign err_count     = err_reg;
   assign busy          = !empty || (state_reg != ST_IDLE);
endmodule

// File: tb/tb_noc_node_injector.sv
// Randomized scoreboard bench for noc_node_injector: a timing/ordering model predicts
// each packet's value and issue edge; a negedge monitor pops and compares.
module tb_noc_node_injector;
   localparam int K = 6, N2 = 13, NODES = 36, DEPTH = 4, GAP = 4;

   typedef struct {
      logic [K-1:0] dest;
      int           acc;
   } req_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [K-1:0] router_name = '0;
   logic [7:0]   tx_count, rx_count, err_count;
   logic         busy;

   noc_node_injector_if #(.K(K), .N2(N2)) bus ();

   noc_node_injector #(.K(K), .N2(N2), .NODES(NODES), .DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .router_name(router_name), .bus(bus),
      .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int   checks = 0, failures = 0;
   int   cyc = 0;
   int   last_e = -1000;
   int   tx_exp = 0, rx_exp = 0, err_exp = 0;
   req_t exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every non-zero packet must match the oldest outstanding request,
   // arriving one edge after acceptance but no sooner than GAP+1 edges after the last.
   always @(negedge clk) begin
      if (rst_n && bus.out_free != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pkt", int'(bus.out_free), 0);
         end else begin
            req_t         e;
            logic [N2-1:0] p;
            int           want;
            e = exp_q.pop_front();
            p = '0;
            p[N2-1] = 1'b1;
            p[K-1:0] = e.dest;
            want = (e.acc + 1 > last_e + GAP + 1) ? e.acc + 1 : last_e + GAP + 1;
            check("pkt_value", int'(bus.out_free), int'(p));
            check("pkt_edge", cyc, want);
            last_e = cyc;
            if (tx_exp < 255) tx_exp++;
         end
      end
   end

   // Called at a negedge; returns at the negedge after acceptance, req_valid low.
   task automatic send(input int d, output int stalls);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_dest  = K'(d);
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      stalls = n;
      if (n >= 100) begin
         check("ready_timeout", 0, 1);
      end else begin
         if (d < NODES) exp_q.push_back('{dest: K'(d), acc: cyc + 1});
         else if (err_exp < 255) err_exp++;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_tx"}, int'(tx_count), tx_exp);
      check({tag, "_rx"}, int'(rx_count), rx_exp);
      check({tag, "_err"}, int'(err_count), err_exp);
   endtask

   task automatic check_reset_state();
      check("rst_out_free", int'(bus.out_free), 0);
      check("rst_ready", int'(bus.req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_tx", int'(tx_count), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_rx", int'(rx_count), 0);
   endtask

   initial begin
      int st;
      bus.req_valid = 1'b0;
      bus.req_dest  = '0;
      bus.in_data   = 1'b0;
      #1;
      check_reset_state();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(9, st);
      $display("txn single dest=9");
      wait_drain();
      check_counts("single");

      send(40, st);
      $display("txn illegal dest=40");
      wait_drain();
      check_counts("illegal");

      for (int d = 1; d <= 6; d++) begin
         send(d, st);
         $display("txn burst dest=%0d stalls=%0d", d, st);
         if (d <= 5) check("burst_no_stall", st, 0);
         if (d == 6) check("burst_full_stall", int'(st > 0), 1);
         if (d < 6) begin
            bus.req_valid = 1'b1;
            bus.req_dest  = K'(d + 1);
         end
      end
      wait_drain();
      check_counts("burst");

      router_name = 6'd17;
      send(17, st);
      $display("txn own-node dest=17");
      for (int i = 0; i < 60; i++) begin
         int d = $urandom_range(0, 47);
         send(d, st);
         $display("txn rand dest=%0d stalls=%0d", d, st);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_drain();
      check_counts("random");

      repeat (3) begin
         bus.in_data = 1'b1;
         rx_exp++;
         @(negedge clk);
      end
      bus.in_data = 1'b0;
      @(negedge clk);
      $display("txn rx pulses=3");
      check("rx_three", int'(rx_count), rx_exp);
      for (int i = 0; i < 300; i++) begin
         bus.in_data = 1'b1;
         if (rx_exp < 255) rx_exp++;
         @(negedge clk);
         bus.in_data = 1'b0;
         @(negedge clk);
      end
      $display("txn rx pulses=300");
      check("rx_saturate", int'(rx_count), 255);
      check_counts("rx");

      send(3, st);
      send(4, st);
      send(5, st);
      $display("txn reset-in-gap queued=%0d", exp_q.size());
      check("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_state();
      exp_q.delete();
      tx_exp = 0;
      rx_exp = 0;
      err_exp = 0;
      last_e = -1000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_counts("post_rst");
      check("post_rst_busy", int'(busy), 0);

      send(5, st);
      $display("txn after-reset dest=5");
      wait_drain();
      check_counts("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
